uart_tx_engine: RTL and testbench

- Serial UART transmitter that sits directly downstream of the FIFO manager's UART TX FIFO port.
- Pops bytes from the FIFO through a valid/ready pop handshake and serialises them onto txd.
- Frame format: LSB first, optional even/odd parity, 1 or 2 stop bits, runtime-programmable bit period.
- Configuration comes from the AXI register block.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 41 ++++
 rtl/uart_tx_engine.sv | 127 ++++++++++++
 tb/tb_uart_tx_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART transmitter types and constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module  : uart_baud_counter
// Brief   : Bit-period timer; bit_end_o marks the last clock of each bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_baud_counter #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 restart_i,
    output logic                 bit_end_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    assign bit_end_o = (cnt_q == div_i);

    // restart realigns the timer so the first bit of a new frame is full length
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================================
// Module  : uart_tx_engine
// Brief   : UART transmitter popping bytes from a FWFT FIFO onto txd.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop2_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 tx_done_o
);

    localparam int             BW         = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  C_LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic                 txd_q;
    logic                 busy_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 parity_en_q;
    logic                 parity_bit_q;
    logic                 stop2_q;

    logic bit_end_d;
    logic frame_end_d;
    logic pop_d;

    uart_baud_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .div_i     (div_q),
        .restart_i (pop_d),
        .bit_end_o (bit_end_d)
    );

    assign frame_end_d = (state_q == STOP) && bit_end_d && (stop_cnt_q == stop2_q);
    // rst gating keeps the FIFO untouched while reset is held
    assign pop_d       = !rst && enable_i && tx_valid_i
                         && ((state_q == IDLE) || frame_end_d);

    assign tx_ready_o = pop_d;
    assign tx_done_o  = frame_end_d;
    assign txd_o      = txd_q;
    assign busy_o     = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            txd_q        <= UART_IDLE_LEVEL;
            busy_q       <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            div_q        <= '0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop2_q      <= 1'b0;
        end else if (pop_d) begin
            state_q      <= START;
            txd_q        <= ~UART_IDLE_LEVEL;
            busy_q       <= 1'b1;
            shift_q      <= tx_data_i;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            div_q        <= baud_div_i;
            parity_en_q  <= parity_en_i;
            parity_bit_q <= (^tx_data_i) ^ parity_odd_i;
            stop2_q      <= stop2_i;
        end else if (bit_end_d) begin
            case (state_q)
                START: begin
                    state_q <= DATA;
                    txd_q   <= shift_q[0];
                end
                DATA: begin
                    shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == C_LAST_BIT) begin
                        state_q <= parity_en_q ? PARITY : STOP;
                        txd_q   <= parity_en_q ? parity_bit_q : UART_IDLE_LEVEL;
                    end else begin
                        txd_q <= shift_q[1];
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    txd_q   <= UART_IDLE_LEVEL;
                end
                STOP: begin
                    if (stop_cnt_q == stop2_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        stop_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`default_nettype none

module tb_uart_tx_engine;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable_i = 1'b0;
    logic [DW-1:0] baud_div_i = '0;
    logic          parity_en_i = 1'b0;
    logic          parity_odd_i = 1'b0;
    logic          stop2_i = 1'b0;
    logic [7:0]    tx_data_i = '0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o;
    logic          txd_o;
    logic          busy_o;
    logic          tx_done_o;

    always #5 clk = ~clk;

    uart_tx_engine #(.DIV_WIDTH(DW), .DATA_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .baud_div_i   (baud_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .txd_o        (txd_o),
        .busy_o       (busy_o),
        .tx_done_o    (tx_done_o)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    bit         pop_flag = 1'b0;
    int         cyc = 0;
    int         ready_cycs[$];
    int         done_cycs[$];
    logic       txd_log[int];

    // Reference model: the whole expected frame as a bit array
    bit m_active = 1'b0;
    int m_cyc = 0;
    int m_per = 1;
    int m_nbits = 10;
    bit m_bits[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        bit e_txd, e_busy, e_done, e_ready;
        int n;
        e_txd  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (m_active) begin
            e_txd  = m_bits[m_cyc / m_per];
            e_busy = 1'b1;
            e_done = (m_cyc == m_nbits * m_per - 1);
        end
        e_ready = !rst && enable_i && tx_valid_i && (!m_active || e_done);

        check("txd",      32'(txd_o),      32'(e_txd));
        check("busy",     32'(busy_o),     32'(e_busy));
        check("tx_done",  32'(tx_done_o),  32'(e_done));
        check("tx_ready", 32'(tx_ready_o), 32'(e_ready));

        txd_log[cyc] = txd_o;
        if (tx_ready_o === 1'b1) begin
            pop_flag = 1'b1;
            ready_cycs.push_back(cyc);
        end
        if (tx_done_o === 1'b1) done_cycs.push_back(cyc);
        cyc++;

        if (rst) begin
            m_active = 1'b0;
        end else if (e_ready) begin
            m_per     = int'(baud_div_i) + 1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[1 + i] = tx_data_i[i];
            n = 9;
            if (parity_en_i) begin
                m_bits[n] = (^tx_data_i) ^ parity_odd_i;
                n++;
            end
            m_bits[n] = 1'b1;
            n++;
            if (stop2_i) begin
                m_bits[n] = 1'b1;
                n++;
            end
            m_nbits  = n;
            m_cyc    = 0;
            m_active = 1'b1;
        end else if (m_active) begin
            if (e_done) m_active = 1'b0;
            else        m_cyc++;
        end
    end

    task automatic drive_fifo();
        tx_valid_i = (q.size() != 0);
        tx_data_i  = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        if (pop_flag) begin
            if (q.size() > 0) void'(q.pop_front());
            pop_flag = 1'b0;
        end
        #1;
        drive_fifo();
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k = 0;
        while (done_cycs.size() < n && k < limit) begin
            tick();
            k++;
        end
        if (done_cycs.size() < n) check("frame_timeout", 32'(done_cycs.size()), 32'(n));
    endtask

    task automatic wait_pop(input int limit);
        int k = 0;
        while (ready_cycs.size() == 0 && k < limit) begin
            tick();
            k++;
        end
        if (ready_cycs.size() == 0) check("pop_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        ready_cycs.delete();
        done_cycs.delete();
    endtask

    function automatic int first_or0(input int qq[$], input int idx);
        return (qq.size() > idx) ? qq[idx] : 0;
    endfunction

    initial begin
        bit seq[10];
        int r, d;
        seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // Reset held with data available: nothing may be popped
        enable_i = 1'b1;
        q.push_back(8'h3C);
        drive_fifo();
        repeat (3) tick();
        check("reset_no_pop", 32'(ready_cycs.size()), 0);
        check("reset_q", 32'(q.size()), 1);
        q.delete();
        drive_fifo();
        rst = 1'b0;
        tick();

        // Single byte 0xA5, 4 clocks per bit
        clear_logs();
        baud_div_i = 16'd3;
        q.push_back(8'hA5);
        drive_fifo();
        wait_frames(1, 200);
        repeat (3) tick();
        r = first_or0(ready_cycs, 0);
        d = first_or0(done_cycs, 0);
        check("a5_pops", 32'(ready_cycs.size()), 1);
        check("a5_len", 32'(d - r), 40);
        check("a5_txd_at_ready", 32'(txd_log[r]), 1);
        for (int i = 0; i < 10; i++) begin
            check("a5_bit_first", 32'(txd_log[r + 1 + 4 * i]), 32'(seq[i]));
            check("a5_bit_last",  32'(txd_log[r + 4 + 4 * i]), 32'(seq[i]));
        end

        // Parity on 0x07 (three ones): even -> 1, odd -> 0; two stop bits
        for (int p = 0; p < 2; p++) begin
            clear_logs();
            baud_div_i   = 16'd1;
            parity_en_i  = 1'b1;
            parity_odd_i = p[0];
            stop2_i      = 1'b1;
            q.push_back(8'h07);
            drive_fifo();
            wait_frames(1, 200);
            repeat (2) tick();
            r = first_or0(ready_cycs, 0);
            d = first_or0(done_cycs, 0);
            check("par_len", 32'(d - r), 24);
            check("par_bit", 32'(txd_log[r + 1 + 2 * 9]), (p == 0) ? 32'd1 : 32'd0);
        end

        // Back-to-back at 1 clock per bit
        clear_logs();
        baud_div_i  = 16'd0;
        parity_en_i = 1'b0;
        stop2_i     = 1'b0;
        q.push_back(8'h55);
        q.push_back(8'h0F);
        drive_fifo();
        wait_frames(2, 100);
        repeat (2) tick();
        check("b2b_pops", 32'(ready_cycs.size()), 2);
        check("b2b_overlap", 32'(first_or0(ready_cycs, 1)), 32'(first_or0(done_cycs, 0)));
        check("b2b_len", 32'(first_or0(done_cycs, 1) - first_or0(ready_cycs, 0)), 20);
        check("b2b_start2", 32'(txd_log[first_or0(ready_cycs, 1) + 1]), 0);

        // Enable drop and divisor change mid-frame
        clear_logs();
        baud_div_i = 16'd2;
        q.push_back(8'h11);
        q.push_back(8'h22);
        drive_fifo();
        wait_pop(50);
        repeat (10) tick();
        enable_i   = 1'b0;
        baud_div_i = 16'd7;
        wait_frames(1, 200);
        repeat (6) tick();
        check("en_len", 32'(first_or0(done_cycs, 0) - first_or0(ready_cycs, 0)), 30);
        check("en_pops", 32'(ready_cycs.size()), 1);
        check("en_q", 32'(q.size()), 1);
        check("en_txd_idle", 32'(txd_o), 1);
        check("en_busy_idle", 32'(busy_o), 0);
        q.delete();
        drive_fifo();

        // Reset inside DATA bit 3
        clear_logs();
        baud_div_i = 16'd3;
        enable_i   = 1'b1;
        q.push_back(8'h81);
        q.push_back(8'h42);
        drive_fifo();
        wait_pop(50);
        repeat (17) tick();
        rst = 1'b1;
        tick();
        check("rst_txd", 32'(txd_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        tick();
        check("rst_pops", 32'(ready_cycs.size()), 1);
        rst = 1'b0;
        wait_frames(1, 200);
        repeat (2) tick();
        check("rst_pops_after", 32'(ready_cycs.size()), 2);
        check("rst_dones", 32'(done_cycs.size()), 1);
        check("rst_q", 32'(q.size()), 0);

        // Randomized traffic with config churn, enable toggling and rare resets
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 15) == 0 && q.size() < 5) q.push_back(8'($urandom));
            if (k % 64 == 0) begin
                baud_div_i   = 16'($urandom_range(0, 3));
                parity_en_i  = 1'($urandom_range(0, 1));
                parity_odd_i = 1'($urandom_range(0, 1));
                stop2_i      = 1'($urandom_range(0, 1));
            end
            enable_i = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 299) == 0);
            drive_fifo();
            tick();
        end
        rst      = 1'b0;
        enable_i = 1'b0;
        repeat (100) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
